// File: rtl/ap_tag_pkg.sv
// Shared constants, resolver state encoding and width helpers for the
// associative-processor tag unit.
package ap_tag_pkg;

    localparam logic [1:0] TAG_LOAD    = 2'b00;
    localparam logic [1:0] TAG_AND_ACC = 2'b01;
    localparam logic [1:0] TAG_OR_ACC  = 2'b10;
    localparam logic [1:0] TAG_CLEAR   = 2'b11;

    typedef enum logic [1:0] {
        RS_IDLE = 2'd0,
        RS_SCAN = 2'd1,
        RS_DONE = 2'd2
    } rs_state_t;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // A count must be able to hold n itself, hence one bit more than an index.
    function automatic int cnt_width(input int n);
        return idx_width(n) + 1;
    endfunction

endpackage

// File: rtl/ap_tag_chunk_scan.sv
// One chunk of the tag snapshot: popcount, lowest set-bit offset and a
// non-zero flag, all combinational.
module ap_tag_chunk_scan
    import ap_tag_pkg::*;
#(
    parameter int SCAN_W = 16,
    parameter int OFF_W  = idx_width(SCAN_W),
    parameter int POP_W  = cnt_width(SCAN_W)
) (
    input  logic [SCAN_W-1:0] chunk,
    output logic [POP_W-1:0]  pop,
    output logic [OFF_W-1:0]  off,
    output logic              nz
);

    always_comb begin
        pop = '0;
        off = '0;
        for (int i = 0; i < SCAN_W; i++) begin
            pop = pop + POP_W'(chunk[i]);
        end
        // Walk downwards so the last hit written is the lowest index.
        for (int i = SCAN_W - 1; i >= 0; i--) begin
            if (chunk[i]) begin
                off = OFF_W'(i);
            end
        end
    end

    assign nz = |chunk;

endmodule

// File: rtl/ap_tag_unit.sv
// Row tag register with multi-pass accumulate modes, TSC tag, and a
// chunked resolver reporting match-any, match count and first match.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RS_IDLE | waiting for resolve_start; snapshot taken on the start edge
// RS_SCAN | one SCAN_W chunk of the snapshot processed per cycle
// RS_DONE | results valid, resolve_done high for this single cycle
module ap_tag_unit
    import ap_tag_pkg::*;
#(
    parameter int DATA_DEPTH = 128,
    parameter int NUM_SRC    = 3,
    parameter int SCAN_W     = 16,
    parameter int IDX_W      = $clog2(DATA_DEPTH),
    parameter int CNT_W      = IDX_W + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC*DATA_DEPTH-1:0] tag_src,
    input  logic [NUM_SRC-1:0]            src_en,
    input  logic [DATA_DEPTH-1:0]         tag_f_tsc,
    input  logic                          in_valid,
    input  logic [1:0]                    mode,
    input  logic                          resolve_start,
    output logic [DATA_DEPTH-1:0]         tag,
    output logic [DATA_DEPTH-1:0]         tag_tsc,
    output logic                          resolve_busy,
    output logic                          resolve_done,
    output logic                          match_any,
    output logic [CNT_W-1:0]              match_cnt,
    output logic [IDX_W-1:0]              first_idx
);

    localparam int NCHUNK = DATA_DEPTH / SCAN_W;
    localparam int PTR_W  = idx_width(NCHUNK);
    localparam int OFF_W  = idx_width(SCAN_W);
    localparam int POP_W  = cnt_width(SCAN_W);

    logic [DATA_DEPTH-1:0] comb;
    rs_state_t             state_q, state_d;
    logic [DATA_DEPTH-1:0] snap;
    logic [PTR_W-1:0]      ptr;
    logic [CNT_W-1:0]      count, count_nxt;
    logic                  found;
    logic [IDX_W-1:0]      first_w, cand;
    logic [SCAN_W-1:0]     chunk;
    logic [POP_W-1:0]      pop;
    logic [OFF_W-1:0]      off;
    logic                  nz;
    logic                  last_chunk;

    // A disabled source contributes all ones, so it never masks a row.
    always_comb begin
        comb = '1;
        for (int s = 0; s < NUM_SRC; s++) begin
            comb = comb & (tag_src[s*DATA_DEPTH +: DATA_DEPTH] | {DATA_DEPTH{~src_en[s]}});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag     <= '0;
            tag_tsc <= '0;
        end else if (in_valid) begin
            case (mode)
                TAG_LOAD:    tag <= comb;
                TAG_AND_ACC: tag <= tag & comb;
                TAG_OR_ACC:  tag <= tag | comb;
                default:     tag <= '0;
            endcase
            tag_tsc <= (mode == TAG_CLEAR) ? '0 : (tag_src[DATA_DEPTH-1:0] & tag_f_tsc);
        end
    end

    assign chunk      = snap[int'(ptr)*SCAN_W +: SCAN_W];
    assign last_chunk = (ptr == PTR_W'(NCHUNK - 1));
    assign count_nxt  = count + CNT_W'(pop);
    assign cand       = IDX_W'(int'(ptr) * SCAN_W) + IDX_W'(off);

    ap_tag_chunk_scan #(
        .SCAN_W (SCAN_W),
        .OFF_W  (OFF_W),
        .POP_W  (POP_W)
    ) u_scan (
        .chunk (chunk),
        .pop   (pop),
        .off   (off),
        .nz    (nz)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RS_IDLE: if (resolve_start) state_d = RS_SCAN;
            RS_SCAN: if (last_chunk)    state_d = RS_DONE;
            RS_DONE:                    state_d = RS_IDLE;
            default:                    state_d = RS_IDLE;
        endcase
    end

    always_comb begin
        resolve_busy = 1'b0;
        resolve_done = 1'b0;
        case (state_q)
            RS_SCAN: resolve_busy = 1'b1;
            RS_DONE: resolve_done = 1'b1;
            default: ;
        endcase
    end

    // Results are written on the final scan edge so they are valid alongside
    // the done pulse, and then hold until the next completed resolve.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap      <= '0;
            ptr       <= '0;
            count     <= '0;
            found     <= 1'b0;
            first_w   <= '0;
            match_any <= 1'b0;
            match_cnt <= '0;
            first_idx <= '0;
        end else begin
            case (state_q)
                RS_IDLE: begin
                    if (resolve_start) begin
                        snap    <= tag;
                        ptr     <= '0;
                        count   <= '0;
                        found   <= 1'b0;
                        first_w <= '0;
                    end
                end
                RS_SCAN: begin
                    count <= count_nxt;
                    ptr   <= ptr + PTR_W'(1);
                    if (!found && nz) begin
                        found   <= 1'b1;
                        first_w <= cand;
                    end
                    if (last_chunk) begin
                        match_cnt <= count_nxt;
                        match_any <= (count_nxt != '0);
                        first_idx <= found ? first_w : (nz ? cand : '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ap_tag_unit.md
Name: ap_tag_unit

Overview:
- Parametrised tag register for the associative processor array.
- Combines NUM_SRC per-row compare results into the row tag, with selectable load/AND-accumulate/OR-accumulate/clear modes for multi-pass compares.
- Also produces the TSC tag (source 0 AND tag_f_tsc).
- Includes a multi-cycle resolver that scans a snapshot of the tag and reports match-any, match count and first (lowest-index) match to the controller.

Parameters:
- DATA_DEPTH, 128, number of rows (tag bits).
- NUM_SRC, 3, number of compare-result sources.
- SCAN_W, 16, tag bits examined per resolver cycle. DATA_DEPTH must be a multiple of SCAN_W.
- IDX_W, $clog2(DATA_DEPTH), row index width.
- CNT_W, IDX_W+1, match count width.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- tag_src, input, NUM_SRC*DATA_DEPTH, source s occupies bits [s*DATA_DEPTH +: DATA_DEPTH].
- src_en, input, NUM_SRC, per-source participation mask.
- tag_f_tsc, input, DATA_DEPTH, TSC flag vector.
- in_valid, input, 1, apply mode this cycle.
- mode, input, 2, 00 LOAD, 01 AND_ACC, 10 OR_ACC, 11 CLEAR.
- resolve_start, input, 1, request a resolve.
- tag, output, DATA_DEPTH, registered row tag.
- tag_tsc, output, DATA_DEPTH, registered TSC tag.
- resolve_busy, output, 1, resolver scanning.
- resolve_done, output, 1, one-cycle pulse when results are valid.
- match_any, output, 1, snapshot has at least one bit set.
- match_cnt, output, CNT_W, popcount of the snapshot.
- first_idx, output, IDX_W, lowest set index, or 0 if none.

Behaviour:
- Reset (rst=1 at a clk edge): every output and all internal state go to 0, and the FSM goes to IDLE. This applies in any state, including mid-scan; no done pulse is issued for an aborted scan.
- comb[i] = AND over s of (tag_src[s][i] | ~src_en[s]). If src_en is all zero, comb is all ones.
- Tag update on the edge when in_valid=1:
  - LOAD: tag <= comb.
  - AND_ACC: tag <= tag & comb.
  - OR_ACC: tag <= tag | comb.
  - CLEAR: tag <= 0.
- tag_tsc on the edge when in_valid=1:
  - CLEAR: tag_tsc <= 0.
  - Every other mode: tag_tsc <= tag_src[0] & tag_f_tsc. This is independent of src_en.
- When in_valid=0, tag and tag_tsc hold. Tag latency is 1 cycle.
- Resolver FSM has three states: IDLE, SCAN, DONE.
- IDLE, on resolve_start=1:
  - snap <= tag (the value before any same-cycle in_valid update), chunk ptr <= 0, count <= 0, found <= 0.
  - resolve_busy <= 1; go to SCAN.
- SCAN, each cycle, processes chunk ptr (bits ptr*SCAN_W .. +SCAN_W-1):
  - count += popcount(chunk).
  - If found=0 and the chunk is non-zero: first_idx <= ptr*SCAN_W + lowest set bit offset, found <= 1.
  - ptr increments. After the chunk DATA_DEPTH/SCAN_W-1, go to DONE.
- DONE, one cycle:
  - match_cnt, match_any (count!=0) and first_idx are registered.
  - resolve_done=1, resolve_busy=0; return to IDLE.
- Resolve latency: done is asserted DATA_DEPTH/SCAN_W+1 cycles after the start cycle (9 at defaults).
- Result outputs hold until the next DONE. If no match: match_any=0, match_cnt=0, first_idx=0.
- resolve_start while busy or in DONE is ignored (not queued).
- in_valid updates during SCAN change tag but not snap.
- match_cnt can reach DATA_DEPTH, which is why CNT_W = IDX_W+1.

Decomposition:
- Package ap_tag_pkg holds:
  - mode constants TAG_LOAD, TAG_AND_ACC, TAG_OR_ACC, TAG_CLEAR;
  - the resolver state enum;
  - the clog2-derived width helpers.
- One sub-module, ap_tag_chunk_scan: combinational SCAN_W-bit popcount plus lowest-set-bit offset and non-zero flag. It is instantiated once and reused every SCAN cycle.

Test Plan:
- Reset, then LOAD with src_en=111, src0=src1=all ones, src2=0x...0F0 -> tag=0x...0F0 one cycle later. Then CLEAR -> tag=0, tag_tsc=0.
- LOAD comb=0xFF00 (low bits), then AND_ACC comb=0x0FF0 -> tag=0x0F00. Then OR_ACC comb=0x000F -> tag=0x0F0F.
- src_en=000, LOAD -> tag all ones. tag_f_tsc=0x5, src0=0x3 -> tag_tsc=0x1.
- tag bits {5,17,127} set, resolve_start -> done exactly 9 cycles later, match_any=1, match_cnt=3, first_idx=5. Busy is high during SCAN only.
- tag=0, resolve -> match_any=0, match_cnt=0, first_idx=0. tag all ones -> match_cnt=128, first_idx=0.
- Same-cycle and mid-operation events:
  - LOAD to bit 3 in the same cycle as resolve_start with old tag bit 64 -> first_idx=64.
  - A second resolve_start while busy -> ignored.
  - rst during SCAN -> outputs 0, no done pulse, next resolve works.
